lcd_timing_gen: RTL and testbench

- Generates horizontal and vertical timing for the 480x272 parallel-RGB LCD, all on clk_lcd.
- Outputs feed the pixel pattern/display blocks: active-region flags, active-pixel coordinates, and an RGB output enable.
- Also drives the panel's sync and data-enable pins, aligned to the two-stage registered pixel pipeline in the display blocks.

---
 rtl/lcd_timing_gen.sv | 146 ++++++++++++++
 tb/tb_lcd_timing_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: horizontal/vertical timing for a parallel-RGB LCD panel.
//
// A free-running pixel/line position is decoded into registered sync pulses,
// active-region flags, active-pixel coordinates and pipeline-aligned enables.
//
// Ports:
//   clk_lcd     in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   disp_on     in   display enable request, sampled only at frame start
//   hsync_n     out  horizontal sync, active low
//   vsync_n     out  vertical sync, active low
//   flagh       out  active pixel within the line (gated by lcd_disp)
//   flagv       out  active line within the frame (gated by lcd_disp)
//   hcount_reg  out  active pixel x index, 0 outside the active pixels
//   Vcount_reg  out  active line y index, 0 outside the active lines
//   rgb_en      out  (flagh & flagv) delayed one clock
//   lcd_de      out  (flagh & flagv) delayed PIPE clocks
//   lcd_disp    out  panel display-on pin
//   frame_start out  one-clock pulse on the cycle presenting line 0, pixel 0
module lcd_timing_gen #(
  parameter int unsigned H_PULSE  = 41,
  parameter int unsigned H_BP     = 2,
  parameter int unsigned H_ACTIVE = 480,
  parameter int unsigned H_FP     = 2,
  parameter int unsigned V_PULSE  = 10,
  parameter int unsigned V_BP     = 2,
  parameter int unsigned V_ACTIVE = 272,
  parameter int unsigned V_FP     = 2,
  parameter int unsigned PIPE     = 2
) (
  input  logic       clk_lcd,
  input  logic       rst_n,
  input  logic       disp_on,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       flagh,
  output logic       flagv,
  output logic [9:0] hcount_reg,
  output logic [8:0] Vcount_reg,
  output logic       rgb_en,
  output logic       lcd_de,
  output logic       lcd_disp,
  output logic       frame_start
);

  localparam int unsigned HW = 10;
  localparam int unsigned VW = 9;

  localparam int unsigned H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;

  // Decode boundaries as inclusive limits so a full-width total never overflows.
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_PULSE - 1);
  localparam logic [HW-1:0] H_ACT_FIRST = HW'(H_PULSE + H_BP);
  localparam logic [HW-1:0] H_ACT_LAST  = HW'(H_PULSE + H_BP + H_ACTIVE - 1);

  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_PULSE - 1);
  localparam logic [VW-1:0] V_ACT_FIRST = VW'(V_PULSE + V_BP);
  localparam logic [VW-1:0] V_ACT_LAST  = VW'(V_PULSE + V_BP + V_ACTIVE - 1);

  // Position that the next clock edge presents on the registered outputs.
  logic [HW-1:0] pos_h;
  logic [VW-1:0] pos_l;

  logic [PIPE-1:0] de_pipe;

  logic h_sync_c;
  logic v_sync_c;
  logic h_act_c;
  logic v_act_c;
  logic frame_top_c;
  logic line_wrap_c;
  logic disp_c;

  // Decode of the upcoming position; registered below.
  always_comb begin
    h_sync_c    = (pos_h <= H_SYNC_LAST);
    v_sync_c    = (pos_l <= V_SYNC_LAST);
    h_act_c     = (pos_h >= H_ACT_FIRST) && (pos_h <= H_ACT_LAST);
    v_act_c     = (pos_l >= V_ACT_FIRST) && (pos_l <= V_ACT_LAST);
    frame_top_c = (pos_h == '0) && (pos_l == '0);
    line_wrap_c = (pos_h == H_LAST);
    // disp_on is only honoured on the edge that presents the frame origin.
    disp_c      = frame_top_c ? disp_on : lcd_disp;
  end

  // Position counters.
  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      pos_h <= '0;
      pos_l <= '0;
    end else begin
      if (line_wrap_c) begin
        pos_h <= '0;
        pos_l <= (pos_l == V_LAST) ? '0 : pos_l + VW'(1);
      end else begin
        pos_h <= pos_h + HW'(1);
      end
    end
  end

  // Registered sync, flag, coordinate and frame outputs.
  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      flagh       <= 1'b0;
      flagv       <= 1'b0;
      hcount_reg  <= '0;
      Vcount_reg  <= '0;
      lcd_disp    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync_n     <= ~h_sync_c;
      vsync_n     <= ~v_sync_c;
      flagh       <= h_act_c & disp_c;
      flagv       <= v_act_c & disp_c;
      hcount_reg  <= (h_act_c && disp_c) ? (pos_h - H_ACT_FIRST) : '0;
      Vcount_reg  <= (v_act_c && disp_c) ? (pos_l - V_ACT_FIRST) : '0;
      lcd_disp    <= disp_c;
      frame_start <= frame_top_c;
    end
  end

  // Enable delay line: rgb_en is one clock behind the active flags, lcd_de PIPE clocks.
  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      rgb_en  <= 1'b0;
      de_pipe <= '0;
    end else if (!disp_c) begin
      rgb_en  <= 1'b0;
      de_pipe <= '0;
    end else begin
      rgb_en     <= flagh & flagv;
      de_pipe[0] <= flagh & flagv;
      for (int i = 1; i < PIPE; i++) begin
        de_pipe[i] <= de_pipe[i-1];
      end
    end
  end

  assign lcd_de = de_pipe[PIPE-1];

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed bench for lcd_timing_gen.
// Horizontal timing uses the panel defaults (525 clocks/line). The vertical
// geometry is shrunk to 2 sync + 1 back porch + 4 active + 1 front porch lines
// (8 lines, 4200 clocks/frame) so several whole frames fit in a short run.
module tb_lcd_timing_gen;

  localparam int unsigned LINE  = 525;
  localparam int unsigned FRAME = 8 * LINE;

  logic       clk_lcd = 1'b0;
  logic       rst_n;
  logic       disp_on;
  logic       hsync_n;
  logic       vsync_n;
  logic       flagh;
  logic       flagv;
  logic [9:0] hcount_reg;
  logic [8:0] Vcount_reg;
  logic       rgb_en;
  logic       lcd_de;
  logic       lcd_disp;
  logic       frame_start;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_timing_gen #(
    .H_PULSE(41), .H_BP(2), .H_ACTIVE(480), .H_FP(2),
    .V_PULSE(2), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .PIPE(2)
  ) dut (
    .clk_lcd    (clk_lcd),
    .rst_n      (rst_n),
    .disp_on    (disp_on),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .flagh      (flagh),
    .flagv      (flagv),
    .hcount_reg (hcount_reg),
    .Vcount_reg (Vcount_reg),
    .rgb_en     (rgb_en),
    .lcd_de     (lcd_de),
    .lcd_disp   (lcd_disp),
    .frame_start(frame_start)
  );

  always #5 clk_lcd = ~clk_lcd;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_lcd);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    disp_on = 1'b1;
    repeat (5) tick();
    n_checks++; if (hsync_n !== 1'b1) $display("FAIL rst_hsync_n: got %b want 1", hsync_n); else n_pass++;
    n_checks++; if (vsync_n !== 1'b1) $display("FAIL rst_vsync_n: got %b want 1", vsync_n); else n_pass++;
    n_checks++; if (flagh !== 1'b0) $display("FAIL rst_flagh: got %b want 0", flagh); else n_pass++;
    n_checks++; if (flagv !== 1'b0) $display("FAIL rst_flagv: got %b want 0", flagv); else n_pass++;
    n_checks++; if (hcount_reg !== 10'd0) $display("FAIL rst_hcount: got %0d want 0", hcount_reg); else n_pass++;
    n_checks++; if (Vcount_reg !== 9'd0) $display("FAIL rst_vcount: got %0d want 0", Vcount_reg); else n_pass++;
    n_checks++; if (rgb_en !== 1'b0) $display("FAIL rst_rgb_en: got %b want 0", rgb_en); else n_pass++;
    n_checks++; if (lcd_de !== 1'b0) $display("FAIL rst_lcd_de: got %b want 0", lcd_de); else n_pass++;
    n_checks++; if (lcd_disp !== 1'b0) $display("FAIL rst_lcd_disp: got %b want 0", lcd_disp); else n_pass++;
    n_checks++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b want 0", frame_start); else n_pass++;

    // First edge after release presents (0,0).
    @(negedge clk_lcd);
    rst_n = 1'b1;
    tick();
    n_checks++; if (frame_start !== 1'b1) $display("FAIL rel_frame_start: got %b want 1", frame_start); else n_pass++;
    n_checks++; if (hsync_n !== 1'b0) $display("FAIL rel_hsync_n: got %b want 0", hsync_n); else n_pass++;
    n_checks++; if (vsync_n !== 1'b0) $display("FAIL rel_vsync_n: got %b want 0", vsync_n); else n_pass++;
    n_checks++; if (lcd_disp !== 1'b1) $display("FAIL rel_lcd_disp: got %b want 1", lcd_disp); else n_pass++;
    tick();
    n_checks++; if (frame_start !== 1'b0) $display("FAIL rel_frame_start_2nd: got %b want 0", frame_start); else n_pass++;

    // Move to p=300 of line 0, then reset asynchronously between edges.
    repeat (299) tick();
    n_checks++; if (hcount_reg !== 10'd257) $display("FAIL p300_hcount: got %0d want 257", hcount_reg); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (hcount_reg !== 10'd0) $display("FAIL async_hcount: got %0d want 0", hcount_reg); else n_pass++;
    n_checks++; if (vsync_n !== 1'b1) $display("FAIL async_vsync_n: got %b want 1", vsync_n); else n_pass++;
    n_checks++; if (flagh !== 1'b0) $display("FAIL async_flagh: got %b want 0", flagh); else n_pass++;
    n_checks++; if (lcd_disp !== 1'b0) $display("FAIL async_lcd_disp: got %b want 0", lcd_disp); else n_pass++;
    repeat (2) tick();
    @(negedge clk_lcd);
    rst_n = 1'b1;
    tick();
    n_checks++; if (frame_start !== 1'b1) $display("FAIL restart_frame_start: got %b want 1", frame_start); else n_pass++;
    n_checks++; if (hsync_n !== 1'b0) $display("FAIL restart_hsync_n: got %b want 0", hsync_n); else n_pass++;
  endtask

  // Entered presenting (0,0); leaves presenting line 1, p=0.
  task automatic test_hline();
    int hs_low = 0, hs_last = -1;
    int fh_cnt = 0, fh_first = -1, fh_last = -1;
    int hc_first = -1, hc_last = -1;
    for (int i = 0; i < int'(LINE); i++) begin
      if (hsync_n === 1'b0) begin hs_low++; hs_last = i; end
      if (flagh === 1'b1) begin
        if (fh_cnt == 0) begin fh_first = i; hc_first = int'(hcount_reg); end
        fh_cnt++;
        fh_last = i;
        hc_last = int'(hcount_reg);
      end
      tick();
    end
    n_checks++; if (hs_low != 41) $display("FAIL hsync_low_clocks: got %0d want 41", hs_low); else n_pass++;
    n_checks++; if (hs_last != 40) $display("FAIL hsync_last_low_p: got %0d want 40", hs_last); else n_pass++;
    n_checks++; if (hsync_n !== 1'b0) $display("FAIL hsync_period_525: got %b want 0", hsync_n); else n_pass++;
    n_checks++; if (fh_cnt != 480) $display("FAIL flagh_clocks: got %0d want 480", fh_cnt); else n_pass++;
    n_checks++; if (fh_first != 43) $display("FAIL flagh_first_p: got %0d want 43", fh_first); else n_pass++;
    n_checks++; if (fh_last != 522) $display("FAIL flagh_last_p: got %0d want 522", fh_last); else n_pass++;
    n_checks++; if (hc_first != 0) $display("FAIL hcount_first: got %0d want 0", hc_first); else n_pass++;
    n_checks++; if (hc_last != 479) $display("FAIL hcount_last: got %0d want 479", hc_last); else n_pass++;
    n_checks++; if (flagv !== 1'b0) $display("FAIL line1_flagv: got %b want 0", flagv); else n_pass++;
  endtask

  // Entered presenting line 1, p=0; leaves presenting (0,0).
  task automatic test_frame();
    int cnt = 0;
    int fs_cnt = 0, vs_low = 0, fv_cnt = 0, fv_first = -1, fhv = 0;
    int vc_a = -1, vc_b = -1, vc_c = -1;
    logic fv_after = 1'bx;
    while (frame_start !== 1'b1 && cnt < 5000) begin
      tick();
      cnt++;
    end
    n_checks++; if (cnt != 7 * int'(LINE)) $display("FAIL wait_frame_start: got %0d clocks want %0d", cnt, 7 * LINE); else n_pass++;
    for (int i = 0; i < int'(FRAME); i++) begin
      if (frame_start === 1'b1) fs_cnt++;
      if (vsync_n === 1'b0) vs_low++;
      if (flagv === 1'b1) begin
        if (fv_cnt == 0) fv_first = i;
        fv_cnt++;
      end
      if (flagh === 1'b1 && flagv === 1'b1) fhv++;
      if (i == 3 * int'(LINE)) vc_a = int'(Vcount_reg);
      if (i == 4 * int'(LINE) + 10) vc_b = int'(Vcount_reg);
      if (i == 6 * int'(LINE) + 500) vc_c = int'(Vcount_reg);
      if (i == 7 * int'(LINE)) fv_after = flagv;
      tick();
    end
    n_checks++; if (fs_cnt != 1) $display("FAIL frame_start_per_frame: got %0d want 1", fs_cnt); else n_pass++;
    n_checks++; if (frame_start !== 1'b1) $display("FAIL frame_period_4200: got %b want 1", frame_start); else n_pass++;
    n_checks++; if (vs_low != 1050) $display("FAIL vsync_low_clocks: got %0d want 1050", vs_low); else n_pass++;
    n_checks++; if (fv_cnt != 2100) $display("FAIL flagv_clocks: got %0d want 2100", fv_cnt); else n_pass++;
    n_checks++; if (fv_first != 1575) $display("FAIL flagv_first: got %0d want 1575", fv_first); else n_pass++;
    n_checks++; if (fhv != 1920) $display("FAIL active_pixels: got %0d want 1920", fhv); else n_pass++;
    n_checks++; if (vc_a != 0) $display("FAIL vcount_line3: got %0d want 0", vc_a); else n_pass++;
    n_checks++; if (vc_b != 1) $display("FAIL vcount_line4: got %0d want 1", vc_b); else n_pass++;
    n_checks++; if (vc_c != 3) $display("FAIL vcount_line6: got %0d want 3", vc_c); else n_pass++;
    n_checks++; if (fv_after !== 1'b0) $display("FAIL flagv_line7: got %b want 0", fv_after); else n_pass++;
  endtask

  // Entered presenting (0,0); leaves presenting line 4, p=2.
  task automatic test_pipeline();
    logic af, af_p, rg_p, de_p;
    int af_r = -1, af_f = -1, rg_r = -1, rg_f = -1, de_r = -1, de_f = -1;
    repeat (3 * LINE) tick();
    af_p = 1'b0; rg_p = 1'b0; de_p = 1'b0;
    for (int i = 0; i < int'(LINE) + 2; i++) begin
      af = flagh & flagv;
      if (af === 1'b1 && af_p === 1'b0 && af_r < 0) af_r = i;
      if (af === 1'b0 && af_p === 1'b1 && af_f < 0) af_f = i;
      if (rgb_en === 1'b1 && rg_p === 1'b0 && rg_r < 0) rg_r = i;
      if (rgb_en === 1'b0 && rg_p === 1'b1 && rg_f < 0) rg_f = i;
      if (lcd_de === 1'b1 && de_p === 1'b0 && de_r < 0) de_r = i;
      if (lcd_de === 1'b0 && de_p === 1'b1 && de_f < 0) de_f = i;
      af_p = af; rg_p = rgb_en; de_p = lcd_de;
      tick();
    end
    n_checks++; if (af_r != 43) $display("FAIL active_rise: got %0d want 43", af_r); else n_pass++;
    n_checks++; if (af_f != 523) $display("FAIL active_fall: got %0d want 523", af_f); else n_pass++;
    n_checks++; if (rg_r != 44) $display("FAIL rgb_en_rise: got %0d want 44", rg_r); else n_pass++;
    n_checks++; if (rg_f != 524) $display("FAIL rgb_en_fall: got %0d want 524", rg_f); else n_pass++;
    n_checks++; if (de_r != 45) $display("FAIL lcd_de_rise: got %0d want 45", de_r); else n_pass++;
    n_checks++; if (de_f != 525) $display("FAIL lcd_de_fall: got %0d want 525", de_f); else n_pass++;
  endtask

  task automatic test_disp_gating();
    int cnt = 0;
    int fhv = 0, rg = 0, de = 0, disp_lo = 0;
    int any_on = 0, hs_low = 0, vs_low = 0, fs_cnt = 0;
    while (frame_start !== 1'b1 && cnt < 5000) begin
      tick();
      cnt++;
    end
    n_checks++; if (frame_start !== 1'b1) $display("FAIL gate_wait_frame_start: got %b want 1 after %0d clocks", frame_start, cnt); else n_pass++;

    // Drop disp_on at the start of line 5: remainder of the frame is unaffected.
    repeat (5 * LINE) tick();
    disp_on = 1'b0;
    for (int i = 0; i < 3 * int'(LINE); i++) begin
      if (flagh === 1'b1 && flagv === 1'b1) fhv++;
      if (rgb_en === 1'b1) rg++;
      if (lcd_de === 1'b1) de++;
      if (lcd_disp !== 1'b1) disp_lo++;
      tick();
    end
    n_checks++; if (fhv != 960) $display("FAIL drop_active_tail: got %0d want 960", fhv); else n_pass++;
    n_checks++; if (rg != 960) $display("FAIL drop_rgb_en_tail: got %0d want 960", rg); else n_pass++;
    n_checks++; if (de != 960) $display("FAIL drop_lcd_de_tail: got %0d want 960", de); else n_pass++;
    n_checks++; if (disp_lo != 0) $display("FAIL drop_lcd_disp_held: got %0d low clocks want 0", disp_lo); else n_pass++;
    n_checks++; if (frame_start !== 1'b1) $display("FAIL off_frame_start: got %b want 1", frame_start); else n_pass++;
    n_checks++; if (lcd_disp !== 1'b0) $display("FAIL off_lcd_disp: got %b want 0", lcd_disp); else n_pass++;

    // Display off for a whole frame; disp_on rises mid-frame with no effect.
    for (int i = 0; i < int'(FRAME); i++) begin
      if (flagh === 1'b1 || flagv === 1'b1 || rgb_en === 1'b1 || lcd_de === 1'b1) any_on++;
      if (hsync_n === 1'b0) hs_low++;
      if (vsync_n === 1'b0) vs_low++;
      if (frame_start === 1'b1) fs_cnt++;
      if (i == 2000) disp_on = 1'b1;
      tick();
    end
    n_checks++; if (any_on != 0) $display("FAIL off_enables: got %0d high clocks want 0", any_on); else n_pass++;
    n_checks++; if (hs_low != 328) $display("FAIL off_hsync_low: got %0d want 328", hs_low); else n_pass++;
    n_checks++; if (vs_low != 1050) $display("FAIL off_vsync_low: got %0d want 1050", vs_low); else n_pass++;
    n_checks++; if (fs_cnt != 1) $display("FAIL off_frame_start_cnt: got %0d want 1", fs_cnt); else n_pass++;
    n_checks++; if (lcd_disp !== 1'b1) $display("FAIL on_lcd_disp: got %b want 1", lcd_disp); else n_pass++;

    // First active pixel of the re-enabled frame, then its delayed enables.
    repeat (3 * LINE + 43) tick();
    n_checks++; if (flagh !== 1'b1) $display("FAIL on_flagh: got %b want 1", flagh); else n_pass++;
    n_checks++; if (flagv !== 1'b1) $display("FAIL on_flagv: got %b want 1", flagv); else n_pass++;
    n_checks++; if (hcount_reg !== 10'd0) $display("FAIL on_hcount: got %0d want 0", hcount_reg); else n_pass++;
    n_checks++; if (Vcount_reg !== 9'd0) $display("FAIL on_vcount: got %0d want 0", Vcount_reg); else n_pass++;
    n_checks++; if (rgb_en !== 1'b0) $display("FAIL on_rgb_en_p43: got %b want 0", rgb_en); else n_pass++;
    tick();
    n_checks++; if (rgb_en !== 1'b1) $display("FAIL on_rgb_en_p44: got %b want 1", rgb_en); else n_pass++;
    n_checks++; if (lcd_de !== 1'b0) $display("FAIL on_lcd_de_p44: got %b want 0", lcd_de); else n_pass++;
    tick();
    n_checks++; if (lcd_de !== 1'b1) $display("FAIL on_lcd_de_p45: got %b want 1", lcd_de); else n_pass++;
  endtask

  initial begin
    rst_n   = 1'b0;
    disp_on = 1'b0;
    test_reset();
    test_hline();
    test_frame();
    test_pipeline();
    test_disp_gating();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
